// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush controller for the 5-stage pipeline: memory freeze, branch flush, load-use bubble.
// Optional stall performance counter built only when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_sequencer #(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_hold,
    output logic                  timeout,
    output logic [15:0]           stall_count
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_stall;
    logic             load_use;

    // Once the watchdog fires, memory waits are ignored until reset.
    assign mem_stall = dmem_req & ~dmem_ready & ~timeout;
    assign load_use  = ex_mem_read & (ex_rd != '0) &
                       ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_hold  = 1'b0;
        if (!rst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (mem_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
        end else if (branch_taken) begin
            // Flush discards the ID instruction, so a coincident load-use needs no stall.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_stall) begin
                        if (wait_cnt == LAST_WAIT) begin
                            timeout  <= 1'b1;
                            state    <= RUN;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (!pc_write) begin
            stall_cnt_q <= sat_inc16(stall_cnt_q);
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'd0;
`endif

endmodule

// File: doc/pipeline_hazard_sequencer.md
# pipeline_hazard_sequencer

Central stall/flush controller for the 5-stage pipeline. Each cycle it decides whether the PC and the IF/ID stage register advance, stall or flush, and whether a bubble enters ID/EX. It resolves three hazard sources in fixed priority:
- multi-cycle data-memory waits;
- taken branches resolved in EX;
- load-use dependencies.

It also keeps a memory-wait watchdog and an optional stall performance counter.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width
- MAX_WAIT, 15, maximum consecutive memory-freeze cycles before timeout (must be ≥2)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- id_rs, id_rt  in  REG_ADDR_W  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  instruction in ID reads rs / rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX
- branch_taken  in  1  branch/jump in EX is taken this cycle
- dmem_req  in  1  MEM stage is issuing a data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register loads its next value
- if_id_write  out  1  IF/ID register captures new PC/instruction
- if_id_flush  out  1  IF/ID register loads a NOP
- id_ex_bubble  out  1  ID/EX register loads a NOP (control zeroed)
- ex_mem_hold  out  1  EX/MEM and MEM/WB hold their contents
- timeout  out  1  sticky memory-watchdog flag
- stall_count  out  16  saturating count of cycles with pc_write=0

## Operation
- States: RUN, MEM_WAIT. The state register, wait_cnt (width $clog2(MAX_WAIT+1)), timeout and stall_count are registered. All other outputs are combinational from state and current inputs.
- Default outputs (no hazard): pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, ex_mem_hold=0.
- mem_stall = dmem_req & ~dmem_ready & ~timeout.
- load_use = ex_mem_read & (ex_rd≠0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Priority, highest first:
  1. mem_stall → freeze: pc_write=0, if_id_write=0, ex_mem_hold=1, id_ex_bubble=0.
  2. branch_taken → pc_write=1, if_id_flush=1, id_ex_bubble=1.
  3. load_use → pc_write=0, if_id_write=0, id_ex_bubble=1.
- RUN:
  - On mem_stall: go to MEM_WAIT, wait_cnt←1.
  - Load-use stall takes one cycle; it clears naturally because the load advances to MEM. No extra state.
- MEM_WAIT:
  - On mem_stall with wait_cnt < MAX_WAIT−1: freeze, wait_cnt←wait_cnt+1.
  - On mem_stall with wait_cnt == MAX_WAIT−1: freeze this cycle (freeze cycle number MAX_WAIT), timeout←1, state←RUN, wait_cnt←0.
  - On dmem_ready: no freeze. Evaluate priorities 2–3 normally; state←RUN, wait_cnt←0.
- After timeout=1, mem_stall is forced 0 (degraded mode: memory waits are ignored) until reset.
- stall_count increments on every cycle with rst high and pc_write=0; it saturates at 16'hFFFF.

## Timing
- Reset (rst low, asynchronous): state=RUN, wait_cnt=0, timeout=0, stall_count=0. While rst is low, all five enable/control outputs are forced 0.
- Decision latency is 0 cycles: control outputs respond to hazard inputs in the same cycle. State changes take effect at the next rising edge.
- A memory access with dmem_ready first high on cycle N (after the request started on cycle S) produces N−S freeze cycles.
- Simultaneous branch_taken and load_use: flush wins. The ID instruction is discarded, so no stall is needed.
- Simultaneous mem_stall and branch_taken: freeze wins. The branch stays in EX and is re-evaluated when the freeze ends.
- Reset asserted in MEM_WAIT: immediate return to RUN; the counters clear.

## Configuration
- PIPE_PERF_CNT_EN defined: the stall_count register and its increment logic are present, as described above.
- PIPE_PERF_CNT_EN undefined: stall_count is tied to 16'd0 and no counter flops are built. All other behaviour is identical.

## Test plan
- Reset: hold rst=0 with random inputs → all controls 0, timeout=0, stall_count=0. Release → pc_write=1, if_id_write=1.
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 for one cycle → pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly that cycle. Same stimulus with ex_rd=0 → no stall.
- Branch vs load-use: branch_taken=1 together with the load-use stimulus above → if_id_flush=1, id_ex_bubble=1, pc_write=1.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles, high on the 4th → exactly 3 freeze cycles with ex_mem_hold=1, then RUN. stall_count +3.
- Timeout (MAX_WAIT=4): dmem_req=1, dmem_ready=0 held → 4 freeze cycles, then timeout=1 and pc_write=1 on following cycles despite dmem_req.
- Reset mid-wait: assert rst in the 2nd MEM_WAIT cycle → outputs 0 immediately. After release, a fresh request freezes again with a full MAX_WAIT budget.
